// File: rtl/f1_sweep_driver.sv
// f1_sweep_driver: drives the f1 gate-level block through all eight {a,b,c}
// input vectors. Each vector is held for SETTLE_CYCLES before f1's x/y
// outputs are captured and compared against the EXP_X/EXP_Y truth tables.
// Reports the captured results, an error count and a pass flag.
// Optional feature macro: SWEEP_STOP_ON_ERR_EN. When it is defined, the
// sweep ends at the first mismatching vector, and {a,b,c} holds that vector.
module f1_sweep_driver #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXP_X         = 8'b0011_1100,
    parameter logic [7:0]  EXP_Y         = 8'b1110_1100
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic       in_start,
    input  logic       in_x,
    input  logic       in_y,
    output logic       out_a,
    output logic       out_b,
    output logic       out_c,
    output logic       out_busy,
    output logic       out_done,
    output logic       out_pass,
    output logic [7:0] out_res_x,
    output logic [7:0] out_res_y,
    output logic [3:0] out_err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SAMPLE,
        ST_FIN
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] settle;
    logic       mismatch;

    // The vector index register drives f1 directly, so {a,b,c} is registered.
    assign out_a = idx[2];
    assign out_b = idx[1];
    assign out_c = idx[0];

    // Compare f1's response for the current vector with the truth tables.
    always_comb begin
        mismatch = (in_x != EXP_X[idx]) || (in_y != EXP_Y[idx]);
    end

    // Sweep sequencer: settles, samples and scores each vector, then reports.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            settle      <= '0;
            out_busy    <= 1'b0;
            out_done    <= 1'b0;
            out_pass    <= 1'b0;
            out_res_x   <= '0;
            out_res_y   <= '0;
            out_err_cnt <= '0;
        end else begin
            out_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_start) begin
                        idx         <= '0;
                        out_busy    <= 1'b1;
                        out_pass    <= 1'b0;
                        out_res_x   <= '0;
                        out_res_y   <= '0;
                        out_err_cnt <= '0;
                        settle      <= SETTLE_LOAD;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    settle <= settle - 4'd1;
                    if (settle == 4'd1) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    out_res_x[idx] <= in_x;
                    out_res_y[idx] <= in_y;
                    if (mismatch) begin
                        out_err_cnt <= out_err_cnt + 4'd1;
                    end
`ifdef SWEEP_STOP_ON_ERR_EN
                    if (mismatch || idx == 3'd7) begin
`else
                    if (idx == 3'd7) begin
`endif
                        out_busy <= 1'b0;
                        state    <= ST_FIN;
                    end else begin
                        idx    <= idx + 3'd1;
                        settle <= SETTLE_LOAD;
                        state  <= ST_WAIT;
                    end
                end
                ST_FIN: begin
                    // The error count already includes the final sample here.
                    out_done <= 1'b1;
                    out_pass <= (out_err_cnt == 4'd0);
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f1_sweep_driver.sv
// Testbench for f1_sweep_driver. Two instances (SETTLE_CYCLES = 2 and 1) share
// the same start and reset inputs. Each one drives its own behavioural f1,
// which answers from per-index response tables. The tables are either
// correct or carry injected faults.
module tb_f1_sweep_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [1:0] x_in, y_in, a, b, c, busy, done, pass;
    logic [7:0] res_x [2];
    logic [7:0] res_y [2];
    logic [3:0] err   [2];

    // f1 response tables indexed by {a,b,c}, shared by both instances.
    logic [7:0] drv_x, drv_y;
    logic [7:0] gx, gy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    f1_sweep_driver #(.SETTLE_CYCLES(2)) u_dut_s2 (
        .in_clk(clk), .in_rst_n(rst_n), .in_start(start),
        .in_x(x_in[0]), .in_y(y_in[0]),
        .out_a(a[0]), .out_b(b[0]), .out_c(c[0]),
        .out_busy(busy[0]), .out_done(done[0]), .out_pass(pass[0]),
        .out_res_x(res_x[0]), .out_res_y(res_y[0]), .out_err_cnt(err[0])
    );

    f1_sweep_driver #(.SETTLE_CYCLES(1)) u_dut_s1 (
        .in_clk(clk), .in_rst_n(rst_n), .in_start(start),
        .in_x(x_in[1]), .in_y(y_in[1]),
        .out_a(a[1]), .out_b(b[1]), .out_c(c[1]),
        .out_busy(busy[1]), .out_done(done[1]), .out_pass(pass[1]),
        .out_res_x(res_x[1]), .out_res_y(res_y[1]), .out_err_cnt(err[1])
    );

    // Behavioural f1: combinational lookup of the current response table.
    always_comb begin
        x_in    = '0;
        y_in    = '0;
        x_in[0] = drv_x[{a[0], b[0], c[0]}];
        y_in[0] = drv_y[{a[0], b[0], c[0]}];
        x_in[1] = drv_x[{a[1], b[1], c[1]}];
        y_in[1] = drv_y[{a[1], b[1], c[1]}];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Golden f1 truth table, derived from x = a ^ b and y = (x & c) | b.
    function automatic void build_golden();
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            gx[i] = v[2] ^ v[1];
            gy[i] = ((v[2] ^ v[1]) & v[0]) | v[1];
        end
    endfunction

    function automatic logic vec_bad(input int i);
        return (drv_x[i] != gx[i]) || (drv_y[i] != gy[i]);
    endfunction

    // Number of vectors the sweep visits before it finishes.
    function automatic int n_vec();
`ifdef SWEEP_STOP_ON_ERR_EN
        for (int i = 0; i < 8; i++) begin
            if (vec_bad(i)) return i + 1;
        end
`endif
        return 8;
    endfunction

    task automatic check_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("%s i%0d abc", tag, k), {29'd0, a[k], b[k], c[k]}, 32'd0);
            check_val($sformatf("%s i%0d busy", tag, k), {31'd0, busy[k]}, 32'd0);
            check_val($sformatf("%s i%0d done", tag, k), {31'd0, done[k]}, 32'd0);
            check_val($sformatf("%s i%0d pass", tag, k), {31'd0, pass[k]}, 32'd0);
            check_val($sformatf("%s i%0d res_x", tag, k), {24'd0, res_x[k]}, 32'd0);
            check_val($sformatf("%s i%0d res_y", tag, k), {24'd0, res_y[k]}, 32'd0);
            check_val($sformatf("%s i%0d err", tag, k), {28'd0, err[k]}, 32'd0);
        end
    endtask

    // One full sweep. It checks abc/busy/done every cycle and the results at the end.
    // poke_t >= 0 re-asserts start for one cycle while the sweep is busy.
    task automatic run_sweep(input string name, input logic [7:0] fx, input logic [7:0] fy,
                             input int poke_t);
        int nv, last, p, ei, e_err;
        logic [7:0] keep;
        drv_x = fx;
        drv_y = fy;
        nv    = n_vec();
        keep  = 8'((16'd1 << nv) - 16'd1);
        e_err = 0;
        for (int i = 0; i < nv; i++) if (vec_bad(i)) e_err++;
        last  = nv * 3 + 2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; ; t++) begin
            for (int k = 0; k < 2; k++) begin
                p  = (k == 0) ? 3 : 2;
                ei = t / p;
                if (ei > nv - 1) ei = nv - 1;
                check_val($sformatf("%s i%0d abc t%0d", name, k, t), {29'd0, a[k], b[k], c[k]}, 32'(ei));
                check_val($sformatf("%s i%0d busy t%0d", name, k, t), {31'd0, busy[k]}, 32'(t < nv * p));
                check_val($sformatf("%s i%0d done t%0d", name, k, t), {31'd0, done[k]}, 32'(t == nv * p + 1));
            end
            if (t == last) break;
            start = (t == poke_t);
            @(posedge clk); #1;
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("%s i%0d res_x", name, k), {24'd0, res_x[k]}, {24'd0, fx & keep});
            check_val($sformatf("%s i%0d res_y", name, k), {24'd0, res_y[k]}, {24'd0, fy & keep});
            check_val($sformatf("%s i%0d err", name, k), {28'd0, err[k]}, 32'(e_err));
            check_val($sformatf("%s i%0d pass", name, k), {31'd0, pass[k]}, 32'(e_err == 0));
        end
    endtask

    initial begin
        logic [7:0] mx, my;
        build_golden();
        drv_x = gx;
        drv_y = gy;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        run_sweep("golden", gx, gy, -1);
        run_sweep("y_stuck0", gx, 8'h00, -1);
        run_sweep("inv_idx4", gx ^ 8'h10, gy ^ 8'h10, -1);
        run_sweep("restart_ignored", gx, gy, 5);

        // Abandon a sweep part-way through with a single reset edge.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_zero("midreset");
        for (int t = 0; t < 30; t++) begin
            @(posedge clk); #1;
            check_val($sformatf("midreset done t%0d", t), {30'd0, done}, 32'd0);
            check_val($sformatf("midreset busy t%0d", t), {30'd0, busy}, 32'd0);
        end
        run_sweep("after_reset", gx, gy, -1);

        for (int r = 0; r < 8; r++) begin
            mx = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom & $urandom);
            my = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom & $urandom);
            run_sweep($sformatf("rand%0d", r), gx ^ mx, gy ^ my, $urandom_range(0, 20) - 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
